seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SCAN_DIV, default 1000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 tick_1hz  in  1  one-cycle enable pulse, 1 Hz; the same strobe that drives the stopwatch enb.
REQ-005 min1, min2, sec1, sec2  in  4 each  BCD digits from the stopwatch, most significant digit first (min1 = tens of minutes).
REQ-006 an  out  4  digit anodes, active-low; an[3]=min1, an[2]=min2, an[1]=sec1, an[0]=sec2.
REQ-007 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 dp  out  1  decimal point, active-low; used as the colon after min2.

Function
REQ-009 Slot counter cnt counts 0..SCAN_DIV-1 and wraps to 0; on wrap, digit index idx advances 0->1->2->3->0.
REQ-010 idx selects the digit: 0=min1, 1=min2, 2=sec1, 3=sec2.
REQ-011 All outputs SHALL be registered, with 1-cycle latency from the (cnt, idx, digit inputs) state to an/seg/dp.
REQ-012 Anti-ghost: when cnt==0, registered an=4'b1111, seg=7'b1111111, dp=1 in the following cycle.
REQ-013 Otherwise, an drives only the bit for idx low.
REQ-014 Otherwise, seg = decode of the selected digit.
REQ-015 Digit inputs are sampled each cycle, so a digit change appears on seg within 1 cycle during its slot.
REQ-016 Decode table for 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-017 Input values 10..15 display a dash, 0111111.
REQ-018 Colon state col toggles on every cycle in which tick_1hz=1.
REQ-019 dp=0 only when idx==1, col==1 and not in the anti-ghost cycle; otherwise dp=1.
REQ-020 A tick_1hz pulse coinciding with a slot wrap applies both updates in the same cycle.
REQ-021 tick_1hz held high toggles col every cycle; no edge detection is performed.

Reset
REQ-022 rst asserted on a clock edge sets cnt=0, idx=0, col=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-023 rst overrides tick_1hz and slot wrap in the same cycle.
REQ-024 rst asserted mid-slot aborts the slot; the first cycle after rst release is the anti-ghost cycle of slot 0.
REQ-025 min1 is lit from the second cycle after rst release.

Configuration
REQ-026 Macro SEG7_LZ_BLANK_EN, when defined: if min1==0, slot 0 keeps an=4'b1111 and seg=7'b1111111 for the whole slot; other slots are unaffected.
REQ-027 Without SEG7_LZ_BLANK_EN, min1==0 displays "0" (1000000) normally.

Structure
REQ-028 Package seg7_pkg holds the segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF, the AN_OFF constant, and the digit-index encoding.
REQ-029 Sub-module seg7_bcd_dec is purely combinational: 4-bit BCD in, 7-bit active-low segments out, per REQ-016 and REQ-017.
REQ-030 seg7_scan owns all registers (cnt, idx, col, output registers).

Verification
REQ-031 The bench SHALL use SCAN_DIV=4 and min1..sec2 = 1,2,3,4. Stimulus: release rst. Required response:
- an sequence 1111, 0111 x3, 1111, 1011 x3, 1111, 1101 x3, 1111, 1110 x3, repeating;
- seg = 1111001, 0100100, 0110000, 0011001 in the matching lit cycles.
REQ-032 Pulse tick_1hz once. Required response: dp=0 during the 3 lit cycles of every min2 slot, dp=1 elsewhere. After a second pulse, dp stays 1.
REQ-033 Drive sec2=4'hC. Required response: seg=0111111 in the sec2 lit cycles.
REQ-034 Set min1=0. Required response:
- with SEG7_LZ_BLANK_EN, an stays 1111 for the whole slot 0;
- without it, an=0111 and seg=1000000 in the slot-0 lit cycles.
REQ-035 Assert rst for 1 cycle during the second lit cycle of the sec1 slot. Required response: outputs go to reset values on the next cycle, then the an sequence restarts at 1111, 0111.
REQ-036 Assert tick_1hz on the exact wrap cycle from idx 0 to idx 1. Required response: the min2 slot shows dp=0 in all 3 lit cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scanner:
// active-low segment patterns, anode values and the digit-slot encoding.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned AN_W  = 4;
   localparam int unsigned BCD_W = 4;
   localparam int unsigned CNT_W = 16;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'b1111111;

   localparam logic [AN_W-1:0]  AN_OFF   = 4'b1111;

   typedef enum logic [1:0] {
      IDX_MIN1 = 2'd0,
      IDX_MIN2 = 2'd1,
      IDX_SEC1 = 2'd2,
      IDX_SEC2 = 2'd3
   } dig_idx_e;

   // Slot 0 drives an[3], slot 3 drives an[0]
   function automatic logic [AN_W-1:0] an_sel(input dig_idx_e idx);
      return ~(AN_W'(4'b1000) >> idx);
   endfunction

endpackage

// File: rtl/seg7_bcd_dec.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module seg7_bcd_dec
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit MM:SS display with blinking colon.
// Optional build macro SEG7_LZ_BLANK_EN blanks a leading zero in the tens-of-minutes digit.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 1000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic [3:0] min1,
   input  logic [3:0] min2,
   input  logic [3:0] sec1,
   input  logic [3:0] sec2,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   dig_idx_e         idx_q, idx_d;
   logic             col_q, col_d;
   logic [AN_W-1:0]  an_q,  an_d;
   logic [SEG_W-1:0] seg_q, seg_d;
   logic             dp_q,  dp_d;

   logic [BCD_W-1:0] dig_sel_c;
   logic [SEG_W-1:0] dig_seg_c;
   logic             wrap_c;

   // Digit mux follows the current slot
   always_comb begin
      dig_sel_c = min1;
      case (idx_q)
         IDX_MIN1: dig_sel_c = min1;
         IDX_MIN2: dig_sel_c = min2;
         IDX_SEC1: dig_sel_c = sec1;
         IDX_SEC2: dig_sel_c = sec2;
         default:  dig_sel_c = min1;
      endcase
   end

   seg7_bcd_dec u_dec (
      .bcd_i (dig_sel_c),
      .seg_o (dig_seg_c)
   );

   assign wrap_c = (cnt_q == CNT_LAST);

   // Next state; first count of each slot is kept dark so the anode switch does not ghost
   always_comb begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
      idx_d = wrap_c ? dig_idx_e'(2'(idx_q + 2'd1)) : idx_q;
      col_d = col_q ^ tick_1hz;
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (cnt_q != '0) begin
         an_d  = an_sel(idx_q);
         seg_d = dig_seg_c;
         dp_d  = ~((idx_q == IDX_MIN2) && col_q);
`ifdef SEG7_LZ_BLANK_EN
         if ((idx_q == IDX_MIN1) && (dig_sel_c == '0)) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= IDX_MIN1;
         col_q <= 1'b0;
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         col_q <= col_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
